// File: rtl/call_stack_master.sv
// rtl/call_stack_master.sv - requester-side call/return/flush controller for the hardware call stack
module call_stack_master #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_SIZE     = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iCall,
    input  logic                        iRet,
    input  logic                        iFlush,
    input  logic [DATA_WIDTH-1:0]       iReturnAddr,
    output logic                        oBusy,
    output logic [DATA_WIDTH-1:0]       oRetAddr,
    output logic                        oRetValid,
    output logic                        oOverflow,
    output logic                        oUnderflow,
    output logic [$clog2(MEM_SIZE):0]   oDepth,
    output logic                        oStackWrite,
    output logic                        oStackRead,
    output logic                        oStackSetSP,
    output logic [$clog2(MEM_SIZE)-1:0] oStackSPValue,
    output logic [DATA_WIDTH-1:0]       oStackData,
    input  logic [DATA_WIDTH-1:0]       iStackData
);
    localparam int            PW   = $clog2(MEM_SIZE);
    localparam int            LW   = $clog2(READ_LATENCY + 1);
    localparam logic [PW:0]   FULL = (PW+1)'(MEM_SIZE);
    localparam logic [LW-1:0] LAT  = LW'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, PUSH, POP_WAIT, POP_CAPTURE, FLUSH} state_t;

    state_t                  state, state_nx;
    logic [LW-1:0]           lat_cnt, lat_cnt_nx;
    logic                    write_nx, read_nx, setsp_nx, retvalid_nx, ovf_nx, unf_nx;
    logic [PW:0]             depth_nx;
    logic [DATA_WIDTH-1:0]   data_nx, retaddr_nx;

    assign oBusy         = (state != IDLE);
    assign oStackSPValue = '0;

    // Strobes are computed one state ahead so they come straight out of flops.
    always_comb begin
        state_nx    = state;
        lat_cnt_nx  = lat_cnt;
        write_nx    = 1'b0;
        read_nx     = 1'b0;
        setsp_nx    = 1'b0;
        retvalid_nx = 1'b0;
        ovf_nx      = oOverflow;
        unf_nx      = oUnderflow;
        depth_nx    = oDepth;
        data_nx     = oStackData;
        retaddr_nx  = oRetAddr;
        case (state)
            IDLE: begin
                if (iFlush) begin
                    state_nx = FLUSH;
                    setsp_nx = 1'b1;
                end else if (iRet) begin
                    if (oDepth == '0) begin
                        unf_nx = 1'b1;
                    end else begin
                        state_nx   = POP_WAIT;
                        read_nx    = 1'b1;
                        lat_cnt_nx = LAT;
                    end
                end else if (iCall) begin
                    if (oDepth == FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        state_nx = PUSH;
                        write_nx = 1'b1;
                        data_nx  = iReturnAddr;
                    end
                end
            end
            PUSH: begin
                depth_nx = oDepth + 1'b1;
                state_nx = IDLE;
            end
            POP_WAIT: begin
                lat_cnt_nx = lat_cnt - 1'b1;
                if (lat_cnt_nx == '0)
                    state_nx = POP_CAPTURE;
            end
            POP_CAPTURE: begin
                retaddr_nx  = iStackData;
                retvalid_nx = 1'b1;
                depth_nx    = oDepth - 1'b1;
                state_nx    = IDLE;
            end
            FLUSH: begin
                depth_nx = '0;
                ovf_nx   = 1'b0;
                unf_nx   = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            oStackWrite <= 1'b0;
            oStackRead  <= 1'b0;
            oStackSetSP <= 1'b0;
            oRetValid   <= 1'b0;
            oOverflow   <= 1'b0;
            oUnderflow  <= 1'b0;
            oDepth      <= '0;
            oStackData  <= '0;
            oRetAddr    <= '0;
        end else begin
            state       <= state_nx;
            lat_cnt     <= lat_cnt_nx;
            oStackWrite <= write_nx;
            oStackRead  <= read_nx;
            oStackSetSP <= setsp_nx;
            oRetValid   <= retvalid_nx;
            oOverflow   <= ovf_nx;
            oUnderflow  <= unf_nx;
            oDepth      <= depth_nx;
            oStackData  <= data_nx;
            oRetAddr    <= retaddr_nx;
        end
    end
endmodule

// File: tb/tb_call_stack_master.sv
// tb/tb_call_stack_master.sv - randomized scoreboard bench for call_stack_master
module tb_call_stack_master;
    localparam int DW = 16;
    localparam int MS = 64;
    localparam int RL = 2;
    localparam int PW = $clog2(MS);

    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_SP = 2;
    localparam int EV_RV = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iCall = 1'b0, iRet = 1'b0, iFlush = 1'b0;
    logic [DW-1:0] iReturnAddr = '0;
    logic [DW-1:0] iStackData = '0;
    logic          oBusy, oRetValid, oOverflow, oUnderflow;
    logic          oStackWrite, oStackRead, oStackSetSP;
    logic [DW-1:0] oRetAddr, oStackData;
    logic [PW:0]   oDepth;
    logic [PW-1:0] oStackSPValue;

    call_stack_master #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .READ_LATENCY(RL)) dut (
        .Clock(Clock), .Reset(Reset), .iCall(iCall), .iRet(iRet), .iFlush(iFlush),
        .iReturnAddr(iReturnAddr), .oBusy(oBusy), .oRetAddr(oRetAddr), .oRetValid(oRetValid),
        .oOverflow(oOverflow), .oUnderflow(oUnderflow), .oDepth(oDepth),
        .oStackWrite(oStackWrite), .oStackRead(oStackRead), .oStackSetSP(oStackSetSP),
        .oStackSPValue(oStackSPValue), .oStackData(oStackData), .iStackData(iStackData)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    ev_t           expq[$];
    logic [DW-1:0] mstack[$];
    bit            movf = 1'b0, munf = 1'b0;
    int            cyc = 0;
    int            total = 0, bad = 0;

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(int kind, logic [DW-1:0] data, int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic observe(int kind, logic [DW-1:0] data);
        ev_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h at cycle %0d, required none", kind, data, cyc);
        end else begin
            e = expq.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_cycle", 64'(cyc), 64'(e.cyc));
            check("event_data", 64'(data), 64'(e.data));
        end
    endtask

    // Monitor: every strobe or return pulse consumes one expected event.
    initial forever begin
        @(negedge Clock);
        if (!Reset) begin
            if (oStackWrite || oStackRead || oStackSetSP)
                check("strobe_exclusive", 64'(int'(oStackWrite) + int'(oStackRead) + int'(oStackSetSP)), 64'd1);
            if (oStackWrite) observe(EV_WR, oStackData);
            if (oStackRead)  observe(EV_RD, '0);
            if (oStackSetSP) observe(EV_SP, DW'(oStackSPValue));
            if (oRetValid)   observe(EV_RV, oRetAddr);
        end
    end

    // Stack memory model with READ_LATENCY; wrong-cycle sampling sees inverted data.
    logic [DW-1:0] smem [MS];
    int            sp = 0, rd_cnt = 0;
    logic [DW-1:0] rd_val = '0;
    initial forever begin
        @(negedge Clock);
        if (Reset) begin
            sp = 0;
            rd_cnt = 0;
        end else begin
            if (rd_cnt > 0) begin
                rd_cnt--;
                iStackData = (rd_cnt == 0) ? rd_val : ~rd_val;
            end else begin
                iStackData = DW'($urandom);
            end
            if (oStackWrite) begin
                if (sp < MS) smem[sp] = oStackData;
                sp++;
            end
            if (oStackRead) begin
                if (sp > 0) sp--;
                rd_val = smem[sp];
                rd_cnt = RL;
            end
            if (oStackSetSP) sp = int'(oStackSPValue);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (oBusy && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (oBusy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got oBusy=1 after 50 cycles, required 0");
        end
    endtask

    // Issue one request at a negedge; expectations come from the abstract stack model.
    task automatic issue(bit f, bit r, bit c, logic [DW-1:0] a);
        int n, ready;
        wait_idle();
        n = cyc;
        iFlush = f;
        iRet = r;
        iCall = c;
        iReturnAddr = a;
        if (f) begin
            expect_ev(EV_SP, '0, n + 1);
            mstack.delete();
            movf = 1'b0;
            munf = 1'b0;
            ready = n + 2;
        end else if (r) begin
            if (mstack.size() == 0) begin
                munf = 1'b1;
                ready = n + 1;
            end else begin
                expect_ev(EV_RD, '0, n + 1);
                expect_ev(EV_RV, mstack.pop_back(), n + 2 + RL);
                ready = n + 2 + RL;
            end
        end else if (c) begin
            if (mstack.size() == MS) begin
                movf = 1'b1;
                ready = n + 1;
            end else begin
                expect_ev(EV_WR, a, n + 1);
                mstack.push_back(a);
                ready = n + 2;
            end
        end else begin
            ready = n + 1;
        end
        @(negedge Clock);
        iFlush = 1'b0;
        iRet = 1'b0;
        iCall = 1'b0;
        iReturnAddr = DW'($urandom);
        while (cyc < ready) @(negedge Clock);
        check("busy_at_ready", 64'(oBusy), 64'd0);
        check("depth", 64'(oDepth), 64'(mstack.size()));
        check("overflow", 64'(oOverflow), 64'(movf));
        check("underflow", 64'(oUnderflow), 64'(munf));
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, 64'(oBusy), 64'd0);
        check({tag, "_retaddr"}, 64'(oRetAddr), 64'd0);
        check({tag, "_retvalid"}, 64'(oRetValid), 64'd0);
        check({tag, "_overflow"}, 64'(oOverflow), 64'd0);
        check({tag, "_underflow"}, 64'(oUnderflow), 64'd0);
        check({tag, "_depth"}, 64'(oDepth), 64'd0);
        check({tag, "_write"}, 64'(oStackWrite), 64'd0);
        check({tag, "_read"}, 64'(oStackRead), 64'd0);
        check({tag, "_setsp"}, 64'(oStackSetSP), 64'd0);
        check({tag, "_spvalue"}, 64'(oStackSPValue), 64'd0);
        check({tag, "_data"}, 64'(oStackData), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clock);

        issue(0, 0, 1, 16'h1234);
        issue(1, 0, 0, '0);

        issue(0, 0, 1, 16'hA000);
        issue(0, 0, 1, 16'hA001);
        issue(0, 0, 1, 16'hA002);
        repeat (3) issue(0, 1, 0, '0);

        issue(0, 1, 0, '0);
        issue(1, 0, 0, '0);

        for (int i = 0; i < MS; i++) issue(0, 0, 1, DW'($urandom));
        issue(0, 0, 1, 16'hBEEF);
        issue(1, 0, 0, '0);

        issue(0, 0, 1, 16'h0011);
        issue(0, 0, 1, 16'h0022);
        issue(0, 1, 1, 16'h0033);

        // Reset during the first POP_WAIT cycle drops the pending return.
        wait_idle();
        n = cyc;
        iRet = 1'b1;
        expect_ev(EV_RD, '0, n + 1);
        @(negedge Clock);
        iRet = 1'b0;
        #2 Reset = 1'b1;
        #1 check_all_zero("midreset");
        expq.delete();
        mstack.delete();
        movf = 1'b0;
        munf = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        issue(0, 0, 1, 16'h5555);
        issue(0, 1, 0, '0);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 99));
            if (op < 4)       issue(1, 0, 0, DW'($urandom));
            else if (op < 38) issue(0, 1, 0, DW'($urandom));
            else if (op < 85) issue(0, 0, 1, DW'($urandom));
            else if (op < 93) issue(0, 1, 1, DW'($urandom));
            else              issue(0, 0, 0, DW'($urandom));
        end

        repeat (10) @(negedge Clock);
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
